// File: rtl/demux3_stage_if.sv
// demux3_stage_if: input stream and three output slot handshakes for demux3_stage
// Ports (signals):
//   in_valid, in_ready, in_data, in_sel   - source side, one word + 2-bit destination
//   out_valid[2:0], out_ready[2:0]        - per-slot consumer handshakes
//   out_data0/1/2                          - slot contents
// slave modport is the demux itself; master modport is the source/consumer environment.
interface demux3_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic [2:0]       out_valid;
    logic [2:0]       out_ready;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2
    );
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2
    );
endinterface

// File: rtl/demux3_stage.sv
// demux3_stage: registered 1-to-3 demultiplexer with per-slot valid/ready and a drop counter
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   bus       demux3_stage_if.slave: input stream and three output slots
//   err_clr   synchronous clear of err and drop_cnt
//   drop_cnt  saturating count of words sent with in_sel==3
//   err       sticky flag, set by any drop
module demux3_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    demux3_stage_if.slave      bus,
    input  logic               err_clr,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic               err
);
    typedef enum logic {EMPTY, FULL} slot_e;
    slot_e            st_q   [3];
    slot_e            st_d   [3];
    logic [WIDTH-1:0] data_q [3];
    logic [WIDTH-1:0] data_d [3];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [3:0]       full4, rdy4;
    logic             acc, drop;
    // Entry 3 models the drop destination: never full, always ready
    assign full4 = {1'b0, st_q[2] == FULL, st_q[1] == FULL, st_q[0] == FULL};
    assign rdy4  = {1'b1, bus.out_ready};
    assign bus.in_ready = !rst && (!full4[bus.in_sel] || rdy4[bus.in_sel]);
    assign acc  = bus.in_valid && bus.in_ready;
    assign drop = acc && bus.in_sel == 2'd3;
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            st_d[k]   = st_q[k];
            data_d[k] = data_q[k];
            if (acc && bus.in_sel == 2'(k)) begin
                st_d[k]   = FULL;
                data_d[k] = bus.in_data;
            end else if (bus.out_ready[k]) begin
                st_d[k] = EMPTY;
            end
        end
        // Clear beats the count, but a coincident drop still raises err
        cnt_d = err_clr ? '0 : (drop && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        err_d = drop || (err_q && !err_clr);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                st_q[k]   <= EMPTY;
                data_q[k] <= '0;
            end
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                st_q[k]   <= st_d[k];
                data_q[k] <= data_d[k];
            end
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign bus.out_valid = {st_q[2] == FULL, st_q[1] == FULL, st_q[0] == FULL};
    assign bus.out_data0 = data_q[0];
    assign bus.out_data1 = data_q[1];
    assign bus.out_data2 = data_q[2];
    assign drop_cnt      = cnt_q;
    assign err           = err_q;
endmodule

// File: tb/tb_demux3_stage.sv
// tb_demux3_stage: directed self-checking bench for demux3_stage
module tb_demux3_stage;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err_clr = 1'b0;
    logic [7:0] drop_cnt;
    logic       err;
    int         n_chk = 0;
    int         n_fail = 0;
    demux3_stage_if #(.WIDTH(32)) bus ();
    demux3_stage #(.WIDTH(32), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .err_clr  (err_clr),
        .drop_cnt (drop_cnt),
        .err      (err)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d);
        bus.in_valid = v;
        bus.in_sel   = s;
        bus.in_data  = d;
        #1;
    endtask
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = '0;
        bus.out_ready = 3'b000;
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_data0", bus.out_data0, 32'h0);
        check("rst_cnt", 32'(drop_cnt), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_ready", 32'(bus.in_ready), 32'h0);
        tick();
        rst = 1'b0;
        // single word to slot 1
        bus.out_ready = 3'b111;
        drive(1'b1, 2'd1, 32'hDEADBEEF);
        check("t1_ready", 32'(bus.in_ready), 32'h1);
        tick();
        drive(1'b0, 2'd0, 32'h0);
        check("t1_valid", 32'(bus.out_valid), 32'h2);
        check("t1_data1", bus.out_data1, 32'hDEADBEEF);
        tick();
        check("t1_drained", 32'(bus.out_valid), 32'h0);
        check("t1_stale", bus.out_data1, 32'hDEADBEEF);
        // back-pressure on slot 0
        bus.out_ready = 3'b110;
        drive(1'b1, 2'd0, 32'h11);
        check("t2_ready_a", 32'(bus.in_ready), 32'h1);
        tick();
        drive(1'b1, 2'd0, 32'h22);
        check("t2_ready_b", 32'(bus.in_ready), 32'h0);
        tick();
        check("t2_hold_data", bus.out_data0, 32'h11);
        check("t2_hold_valid", 32'(bus.out_valid), 32'h1);
        bus.out_ready = 3'b111;
        #1;
        check("t2_ready_c", 32'(bus.in_ready), 32'h1);
        tick();
        drive(1'b0, 2'd0, 32'h0);
        check("t2_replace", bus.out_data0, 32'h22);
        check("t2_valid", 32'(bus.out_valid), 32'h1);
        tick();
        check("t2_empty", 32'(bus.out_valid), 32'h0);
        // slot 2 stalled, slot 0 independent
        bus.out_ready = 3'b011;
        drive(1'b1, 2'd2, 32'h77);
        tick();
        check("t3_s2_full", 32'(bus.out_valid), 32'h4);
        drive(1'b1, 2'd2, 32'h88);
        check("t3_s2_block", 32'(bus.in_ready), 32'h0);
        drive(1'b1, 2'd0, 32'hA5);
        check("t3_s0_ready", 32'(bus.in_ready), 32'h1);
        tick();
        drive(1'b0, 2'd0, 32'h0);
        check("t3_valid", 32'(bus.out_valid), 32'h5);
        check("t3_data0", bus.out_data0, 32'hA5);
        check("t3_data2", bus.out_data2, 32'h77);
        bus.out_ready = 3'b111;
        tick();
        check("t3_drain", 32'(bus.out_valid), 32'h0);
        // streaming into slot 2
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 2'd2, 32'(i));
            check($sformatf("t4_ready%0d", i), 32'(bus.in_ready), 32'h1);
            tick();
            check($sformatf("t4_data%0d", i), bus.out_data2, 32'(i));
            check($sformatf("t4_valid%0d", i), 32'(bus.out_valid), 32'h4);
        end
        drive(1'b0, 2'd0, 32'h0);
        tick();
        // drops and saturation
        bus.out_ready = 3'b000;
        drive(1'b1, 2'd3, 32'h55);
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 9) check("t5_cnt10", 32'(drop_cnt), 32'd10);
        end
        drive(1'b0, 2'd0, 32'h0);
        check("t5_sat", 32'(drop_cnt), 32'd255);
        check("t5_err", 32'(err), 32'h1);
        check("t5_valid", 32'(bus.out_valid), 32'h0);
        err_clr = 1'b1;
        drive(1'b1, 2'd3, 32'h66);
        tick();
        check("t5_clr_cnt", 32'(drop_cnt), 32'h0);
        check("t5_clr_err", 32'(err), 32'h1);
        drive(1'b0, 2'd0, 32'h0);
        tick();
        err_clr = 1'b0;
        check("t5_clr_err2", 32'(err), 32'h0);
        // async reset with all slots full
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'(i), 32'h100 + 32'(i));
            tick();
        end
        drive(1'b1, 2'd3, 32'h0);
        tick();
        drive(1'b0, 2'd0, 32'h0);
        check("t6_full", 32'(bus.out_valid), 32'h7);
        check("t6_cnt", 32'(drop_cnt), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_valid", 32'(bus.out_valid), 32'h0);
        check("t6_cnt0", 32'(drop_cnt), 32'h0);
        check("t6_err0", 32'(err), 32'h0);
        check("t6_data1", bus.out_data1, 32'h0);
        check("t6_ready", 32'(bus.in_ready), 32'h0);
        tick();
        rst = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
